// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_sel, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op_sel, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO; one 33-bit add/sub per cycle.
// Optional macro MDU_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier is zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;
  logic             done_nxt, dz_nxt;
  logic             load, step, fix, run_last, mt_ok;

  logic [WIDTH-1:0] work_hi, work_lo, operand;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_res, neg_rem;

  // op_sel[1] selects divide, op_sel[0] selects the unsigned variant
  logic             start_div, start_signed, rs_neg, rt_neg, div_zero;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign start_div    = bus.op_sel[1];
  assign start_signed = ~bus.op_sel[0];
  assign rs_neg       = start_signed & bus.rs_val[WIDTH-1];
  assign rt_neg       = start_signed & bus.rt_val[WIDTH-1];
  assign rs_abs       = rs_neg ? WIDTH'(0) - bus.rs_val : bus.rs_val;
  assign rt_abs       = rt_neg ? WIDTH'(0) - bus.rt_val : bus.rt_val;
  assign div_zero     = start_div & (bus.rt_val == '0);
  assign mt_ok        = (state == IDLE) & ~bus.start;

  // Shared 33-bit adder/subtractor: carry_in=1 selects subtract
  logic [AW-1:0] add_a, add_b, add_sum;
  logic          add_sub;

  assign add_a   = is_div ? {work_hi, work_lo[WIDTH-1]} : {1'b0, work_hi};
  assign add_b   = {1'b0, operand};
  assign add_sub = is_div;
  assign add_sum = add_a + (add_sub ? ~add_b : add_b) + AW'(add_sub);

  logic          trial_ok;
  logic [AW-1:0] mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign trial_ok = ~add_sum[AW-1];
  assign mul_sum  = work_lo[0] ? add_sum : {1'b0, work_hi};

  // One shift-add (multiply) or restoring step (divide)
  always_comb begin
    step_hi = mul_sum[AW-1:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = trial_ok ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], trial_ok};
    end
  end

`ifdef MDU_EARLY_TERM_EN
  logic [WIDTH-1:0] mrem;
  logic [CNT_W-1:0] shamt;
  logic [PW-1:0]    prod_raw;

  // Skipped iterations would only shift right, so apply them in one go at FIX
  assign shamt    = CNT_W'(WIDTH) - cnt;
  assign prod_raw = {work_hi, work_lo} >> shamt;
  assign run_last = (cnt == CNT_W'(WIDTH - 1)) | (~is_div & (mrem[WIDTH-1:1] == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mrem <= '0;
    end else if (load) begin
      mrem <= rt_abs;
    end else if (step) begin
      mrem <= mrem >> 1;
    end
  end
`else
  logic [PW-1:0] prod_raw;

  assign prod_raw = {work_hi, work_lo};
  assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  assign prod = neg_res ? PW'(0) - prod_raw : prod_raw;
  assign quo  = neg_res ? WIDTH'(0) - work_lo : work_lo;
  assign rem  = neg_rem ? WIDTH'(0) - work_hi : work_hi;

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= done_nxt;
      dz_q   <= dz_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    done_nxt  = 1'b0;
    dz_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (div_zero) begin
            done_nxt = 1'b1;
            dz_nxt   = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (run_last) state_nxt = FIX;
      end
      FIX: begin
        fix       = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers, sign bookkeeping and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_hi <= '0;
      work_lo <= '0;
      operand <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (load) begin
        work_hi <= '0;
        work_lo <= start_div ? rs_abs : rt_abs;
        operand <= start_div ? rt_abs : rs_abs;
        cnt     <= '0;
        is_div  <= start_div;
        neg_res <= rs_neg ^ rt_neg;
        neg_rem <= rs_neg;
      end else if (step) begin
        work_hi <= step_hi;
        work_lo <= step_lo;
        cnt     <= cnt + CNT_W'(1);
      end

      if (fix) begin
        if (is_div) begin
          lo_q <= quo;
          hi_q <= rem;
        end else begin
          hi_q <= prod[PW-1:WIDTH];
          lo_q <= prod[WIDTH-1:0];
        end
      end else if (mt_ok) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (honours MDU_EARLY_TERM_EN for latency).
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected edges from start to the done sample
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] m;
    int it;
    if (op[1]) return 33;
    m  = (!op[0] && b[31]) ? 32'd0 - b : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
    return it + 1;
`else
    return (op[1] | b[0]) ? 33 : 33;
`endif
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic dz);
    bus.op_sel = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    lat        = 0;
    busy_cnt   = bus.busy ? 1 : 0;
    dz         = bus.div_by_zero;
    while (!bus.done && lat < 60) begin
      tick();
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) dz = bus.div_by_zero;
    end
  endtask

  initial begin
    int   lat, bc, seen;
    logic dz;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_sel = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    tick();
    tick();
    check("rst_hi",   64'(bus.hi), 64'h0);
    check("rst_lo",   64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_dz",   64'(bus.div_by_zero), 64'h0);
    rst_n = 1'b1;
    tick();

    // MTHI / MTLO
    bus.hi_we = 1'b1; bus.wdata = 32'h11; tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22; tick();
    bus.lo_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'h11);
    check("mtlo", 64'(bus.lo), 64'h22);

    // DIVU by zero with MT strobes alongside the accepted start
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h99;
    run_op(2'b11, 32'd100, 32'd0, lat, bc, dz);
    check("dz_lat",  64'(lat), 64'd0);
    check("dz_flag", 64'(dz), 64'h1);
    check("dz_busy", 64'(bc), 64'd0);
    check("dz_hi",   64'(bus.hi), 64'h11);
    check("dz_lo",   64'(bus.lo), 64'h22);
    tick();
    check("dz_done_pulse", 64'(bus.done), 64'h0);
    check("dz_flag_pulse", 64'(bus.div_by_zero), 64'h0);

    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{2'b01, 32'h00000007, 32'h00000003, 32'h00000000, 32'h00000015});
    vecs.push_back('{2'b01, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000});
    vecs.push_back('{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});
    vecs.push_back('{2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006});
    vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, dz);
      check($sformatf("v%0d_hi", i),   64'(bus.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i),   64'(bus.lo), 64'(vecs[i].lo));
      check($sformatf("v%0d_lat", i),  64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("v%0d_busy", i), 64'(bc), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("v%0d_dz", i),   64'(dz), 64'h0);
      tick();
      check($sformatf("v%0d_pulse", i), 64'(bus.done), 64'h0);
    end

    // Start while busy is ignored; MTLO while busy is ignored
    bus.op_sel = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    repeat (4) begin tick(); lat++; end
    bus.op_sel = 2'b11; bus.rs_val = 32'd9; bus.rt_val = 32'd0; bus.start = 1'b1;
    bus.lo_we = 1'b1; bus.wdata = 32'hBAD;
    tick(); lat++;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check("ign_busy", 64'(bus.busy), 64'h1);
    check("ign_dz",   64'(bus.div_by_zero), 64'h0);
    check("ign_mtlo", 64'(bus.lo), 64'hFFFFFFFF);
    while (!bus.done && lat < 60) begin tick(); lat++; end
    check("ign_lat", 64'(lat), 64'(exp_lat(2'b01, 32'd4)));
    check("ign_hi",  64'(bus.hi), 64'h0);
    check("ign_lo",  64'(bus.lo), 64'hC);
    tick();

    // Reset at cycle 10 of a MULTU discards it
    bus.op_sel = 2'b01; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'hFFFFFFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.lo_we = 1'b1; bus.wdata = 32'h55555555;
    tick();
    bus.lo_we = 1'b0;
    check("rmid_mtlo", 64'(bus.lo), 64'hC);
    bus.op_sel = 2'b11; bus.rs_val = 32'd9; bus.rt_val = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rmid_busy", 64'(bus.busy), 64'h1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmid_hi",   64'(bus.hi), 64'h0);
    check("rmid_lo",   64'(bus.lo), 64'h0);
    check("rmid_idle", 64'(bus.busy), 64'h0);
    check("rmid_done", 64'(bus.done), 64'h0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    check("rmid_quiet", 64'(seen), 64'd0);
    check("rmid_lo_end", 64'(bus.lo), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
